// File: rtl/fifo_pkg.sv
// Shared helpers for the parametrised synchronous FIFO: width functions and
// read-mode constants.
package fifo_pkg;

    localparam bit FWFT_STD = 1'b0;
    localparam bit FWFT_ON  = 1'b1;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result++;
            v = v >> 1;
        end
        return result;
    endfunction

    // Pointers carry one extra wrap bit above the RAM address.
    function automatic int ptr_w(input int addr_w);
        return addr_w + 1;
    endfunction

    // Count must represent 0..DEPTH inclusive.
    function automatic int cnt_w(input int addr_w);
        return addr_w + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_param_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port, no reset,
// so synthesis maps it onto block RAM.
module sdp_ram #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with configurable width/depth, standard or FWFT read mode,
// exact fill count, programmable almost flags and sticky error flags.
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8,
    parameter bit FWFT   = FWFT_STD
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   fill_cnt,
    input  logic [ADDR_W:0]   af_thresh,
    input  logic [ADDR_W:0]   ae_thresh,
    output logic              overflow,
    output logic              underflow,
    input  logic              clr_err
);

    localparam int PTR_W = ptr_w(ADDR_W);
    localparam int CNT_W = cnt_w(ADDR_W);
    localparam logic [CNT_W-1:0] DEPTH_C = {1'b1, {ADDR_W{1'b0}}};

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  ram_cnt;
    logic [CNT_W-1:0]  fill_nxt;
    logic [DATA_W-1:0] ram_data_p1;
    logic              vld_p1;
    logic              empty_q;
    logic              wr_acc;
    logic              rd_acc;
    logic              ram_rd;
    logic              out_load;

    assign ram_cnt = wr_ptr - rd_ptr;
    assign wr_acc  = wr_en && !full;
    assign rd_acc  = rd_en && !empty;
    assign empty   = (FWFT == FWFT_ON) ? !rd_valid : empty_q;

    // In FWFT mode the RAM output register acts as a one-word skid stage, so a
    // pop can be refilled from it on the same edge without a bubble.
    always_comb begin
        out_load = 1'b0;
        ram_rd   = 1'b0;
        if (FWFT == FWFT_ON) begin
            out_load = vld_p1 && (!rd_valid || rd_acc);
            ram_rd   = (ram_cnt != '0) && (!vld_p1 || out_load);
        end else begin
            out_load = vld_p1;
            ram_rd   = rd_acc;
        end
    end

    always_comb begin
        fill_nxt = fill_cnt;
        if (wr_acc && !rd_acc) begin
            fill_nxt = fill_cnt + CNT_W'(1);
        end else if (rd_acc && !wr_acc) begin
            fill_nxt = fill_cnt - CNT_W'(1);
        end
    end

    // Stage p0 -> p1: RAM write and registered RAM read
    sdp_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr[ADDR_W-1:0]),
        .wr_data (wr_data),
        .rd_en   (ram_rd),
        .rd_addr (rd_ptr[ADDR_W-1:0]),
        .rd_data (ram_data_p1)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fill_cnt     <= '0;
            vld_p1       <= 1'b0;
            rd_valid     <= 1'b0;
            rd_data      <= '0;
            empty_q      <= 1'b1;
            full         <= 1'b0;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (ram_rd) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end

            // Flags come from the next count so they never lag fill_cnt.
            fill_cnt     <= fill_nxt;
            empty_q      <= (fill_nxt == '0);
            full         <= (fill_nxt == DEPTH_C);
            almost_full  <= (fill_nxt >= af_thresh);
            almost_empty <= (fill_nxt <= ae_thresh);

            vld_p1 <= ram_rd || (vld_p1 && !out_load);

            // Stage p1 -> output register
            if (out_load) begin
                rd_data  <= ram_data_p1;
                rd_valid <= 1'b1;
            end else if (FWFT != FWFT_ON || rd_acc) begin
                rd_valid <= 1'b0;
            end

            if (wr_en && full) begin
                overflow <= 1'b1;
            end else if (clr_err) begin
                overflow <= 1'b0;
            end
            if (rd_en && empty) begin
                underflow <= 1'b1;
            end else if (clr_err) begin
                underflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param: a 16-deep standard-mode instance and a
// 16-deep FWFT instance, with hand-computed expected values.
module tb_sync_fifo_param;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        s_wr_en = 1'b0;
    logic [31:0] s_wr_data = '0;
    logic        s_rd_en = 1'b0;
    logic [31:0] s_rd_data;
    logic        s_rd_valid, s_full, s_empty, s_afull, s_aempty;
    logic [4:0]  s_fill;
    logic [4:0]  s_af = 5'd12;
    logic [4:0]  s_ae = 5'd3;
    logic        s_ovf, s_unf;
    logic        s_clr = 1'b0;

    logic        f_wr_en = 1'b0;
    logic [31:0] f_wr_data = '0;
    logic        f_rd_en = 1'b0;
    logic [31:0] f_rd_data;
    logic        f_rd_valid, f_full, f_empty, f_afull, f_aempty;
    logic [4:0]  f_fill;
    logic [4:0]  f_af = 5'd12;
    logic [4:0]  f_ae = 5'd3;
    logic        f_ovf, f_unf;
    logic        f_clr = 1'b0;

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    sync_fifo_param #(.DATA_W(32), .ADDR_W(4), .FWFT(1'b0)) u_std (
        .clk (clk), .rst_n (rst_n),
        .wr_en (s_wr_en), .wr_data (s_wr_data), .rd_en (s_rd_en),
        .rd_data (s_rd_data), .rd_valid (s_rd_valid),
        .full (s_full), .empty (s_empty),
        .almost_full (s_afull), .almost_empty (s_aempty),
        .fill_cnt (s_fill), .af_thresh (s_af), .ae_thresh (s_ae),
        .overflow (s_ovf), .underflow (s_unf), .clr_err (s_clr)
    );

    sync_fifo_param #(.DATA_W(32), .ADDR_W(4), .FWFT(1'b1)) u_fwft (
        .clk (clk), .rst_n (rst_n),
        .wr_en (f_wr_en), .wr_data (f_wr_data), .rd_en (f_rd_en),
        .rd_data (f_rd_data), .rd_valid (f_rd_valid),
        .full (f_full), .empty (f_empty),
        .almost_full (f_afull), .almost_empty (f_aempty),
        .fill_cnt (f_fill), .af_thresh (f_af), .ae_thresh (f_ae),
        .overflow (f_ovf), .underflow (f_unf), .clr_err (f_clr)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic cyc(input logic we, input logic [31:0] wd, input logic re, input logic clr);
        s_wr_en = we;
        s_wr_data = wd;
        s_rd_en = re;
        s_clr = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic fcyc(input logic we, input logic [31:0] wd, input logic re);
        f_wr_en = we;
        f_wr_data = wd;
        f_rd_en = re;
        @(posedge clk);
        #1;
    endtask

    // Read order during the wrap test: 0x77, 0x100..0x103, then 0x200 onward.
    function automatic logic [31:0] wrap_val(input int idx);
        if (idx == 0) return 32'h77;
        if (idx < 5) return 32'h100 + 32'(idx - 1);
        return 32'h200 + 32'(idx - 5);
    endfunction

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_fill", 32'(s_fill), 0);
        chk("rst_empty", 32'(s_empty), 1);
        chk("rst_full", 32'(s_full), 0);
        chk("rst_afull", 32'(s_afull), 0);
        chk("rst_aempty", 32'(s_aempty), 1);
        chk("rst_valid", 32'(s_rd_valid), 0);
        chk("rst_data", s_rd_data, 0);
        chk("rst_ovf", 32'(s_ovf), 0);
        chk("rst_unf", 32'(s_unf), 0);
        chk("rst_f_empty", 32'(f_empty), 1);
        rst_n = 1'b1;
        cyc(0, 0, 0, 0);

        // Fill 0x00..0x0F, checking count and threshold flags on every edge
        for (int i = 0; i < 16; i++) begin
            cyc(1, 32'(i), 0, 0);
            chk("fill_cnt", 32'(s_fill), 32'(i + 1));
            chk("fill_afull", 32'(s_afull), 32'((i + 1) >= 12));
            chk("fill_aempty", 32'(s_aempty), 32'((i + 1) <= 3));
        end
        chk("fill_full", 32'(s_full), 1);
        chk("fill_empty", 32'(s_empty), 0);

        // Full with both requests: read wins, write of 0xDEAD rejected
        cyc(1, 32'hDEAD, 1, 0);
        chk("ovf_set", 32'(s_ovf), 1);
        chk("ovf_fill", 32'(s_fill), 15);
        chk("ovf_full", 32'(s_full), 0);
        chk("ovf_lat_valid", 32'(s_rd_valid), 0);

        // Drain; af_thresh drops to 8 while the count is 10
        for (int k = 1; k < 16; k++) begin
            if (k == 6) s_af = 5'd8;
            cyc(0, 0, 1, k == 1);
            chk("drain_valid", 32'(s_rd_valid), 1);
            chk("drain_data", s_rd_data, 32'(k - 1));
            chk("drain_fill", 32'(s_fill), 32'(15 - k));
            chk("drain_afull", 32'(s_afull), 32'((15 - k) >= ((k >= 6) ? 8 : 12)));
            chk("drain_aempty", 32'(s_aempty), 32'((15 - k) <= 3));
            if (k == 1) chk("ovf_clr", 32'(s_ovf), 0);
        end
        chk("drain_empty", 32'(s_empty), 1);
        cyc(0, 0, 0, 0);
        chk("last_valid", 32'(s_rd_valid), 1);
        chk("last_data", s_rd_data, 32'h0F);
        cyc(0, 0, 0, 0);
        chk("valid_1cyc", 32'(s_rd_valid), 0);
        chk("data_hold", s_rd_data, 32'h0F);

        // Underflow, set-wins-over-clear, and write-only acceptance when empty
        cyc(0, 0, 1, 0);
        chk("unf_set", 32'(s_unf), 1);
        chk("unf_fill", 32'(s_fill), 0);
        cyc(0, 0, 0, 0);
        chk("unf_valid", 32'(s_rd_valid), 0);
        chk("unf_data", s_rd_data, 32'h0F);
        cyc(0, 0, 1, 1);
        chk("unf_setwins", 32'(s_unf), 1);
        cyc(0, 0, 0, 1);
        chk("unf_clr", 32'(s_unf), 0);
        cyc(1, 32'h77, 1, 0);
        chk("empty_both_fill", 32'(s_fill), 1);
        chk("empty_both_unf", 32'(s_unf), 1);
        chk("empty_both_empty", 32'(s_empty), 0);
        cyc(0, 0, 0, 1);

        // Wrap-around: hold count at 5 with 40 simultaneous read/write cycles
        for (int i = 0; i < 4; i++) cyc(1, 32'h100 + 32'(i), 0, 0);
        chk("wrap_pre_fill", 32'(s_fill), 5);
        for (int i = 0; i < 40; i++) begin
            cyc(1, 32'h200 + 32'(i), 1, 0);
            chk("wrap_fill", 32'(s_fill), 5);
            if (i == 0) begin
                chk("wrap_valid0", 32'(s_rd_valid), 0);
            end else begin
                chk("wrap_valid", 32'(s_rd_valid), 1);
                chk("wrap_data", s_rd_data, wrap_val(i - 1));
            end
        end
        for (int j = 0; j < 5; j++) begin
            cyc(0, 0, 1, 0);
            chk("wrap_drain_data", s_rd_data, wrap_val(39 + j));
            chk("wrap_drain_fill", 32'(s_fill), 32'(4 - j));
        end
        cyc(0, 0, 0, 0);
        chk("wrap_last_data", s_rd_data, 32'h227);
        chk("wrap_empty", 32'(s_empty), 1);

        // Reset in the middle of a stream at count 7
        for (int i = 0; i < 7; i++) cyc(1, 32'h300 + 32'(i), 0, 0);
        chk("mid_fill", 32'(s_fill), 7);
        s_wr_en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_fill", 32'(s_fill), 0);
        chk("mid_rst_empty", 32'(s_empty), 1);
        chk("mid_rst_aempty", 32'(s_aempty), 1);
        chk("mid_rst_afull", 32'(s_afull), 0);
        chk("mid_rst_data", s_rd_data, 0);
        chk("mid_rst_valid", 32'(s_rd_valid), 0);
        #1;
        rst_n = 1'b1;
        cyc(0, 0, 0, 0);
        chk("post_rst_fill", 32'(s_fill), 0);
        chk("post_rst_valid", 32'(s_rd_valid), 0);
        cyc(1, 32'h1, 0, 0);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 0, 0);
        chk("post_rst_rvalid", 32'(s_rd_valid), 1);
        chk("post_rst_rdata", s_rd_data, 32'h1);
        chk("post_rst_empty", 32'(s_empty), 1);

        // FWFT: 0xA5 written at edge N appears after edge N+2
        fcyc(1, 32'hA5, 0);
        chk("fwft_n_valid", 32'(f_rd_valid), 0);
        chk("fwft_n_fill", 32'(f_fill), 1);
        chk("fwft_n_empty", 32'(f_empty), 1);
        fcyc(0, 0, 0);
        chk("fwft_n1_valid", 32'(f_rd_valid), 0);
        fcyc(0, 0, 0);
        chk("fwft_n2_valid", 32'(f_rd_valid), 1);
        chk("fwft_n2_data", f_rd_data, 32'hA5);
        chk("fwft_n2_empty", 32'(f_empty), 0);
        for (int i = 0; i < 4; i++) fcyc(1, 32'hB0 + 32'(i), 0);
        fcyc(0, 0, 0);
        fcyc(0, 0, 0);
        chk("fwft_fill5", 32'(f_fill), 5);
        chk("fwft_head_hold", f_rd_data, 32'hA5);
        for (int i = 0; i < 4; i++) begin
            fcyc(0, 0, 1);
            chk("fwft_pop_valid", 32'(f_rd_valid), 1);
            chk("fwft_pop_data", f_rd_data, 32'hB0 + 32'(i));
            chk("fwft_pop_fill", 32'(f_fill), 32'(4 - i));
        end
        fcyc(0, 0, 1);
        chk("fwft_end_valid", 32'(f_rd_valid), 0);
        chk("fwft_end_empty", 32'(f_empty), 1);
        chk("fwft_end_fill", 32'(f_fill), 0);
        chk("fwft_end_unf", 32'(f_unf), 0);
        fcyc(0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
